// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table capture block.
// Pure declarations: no latency, no flow control.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } tt_state_e;

  localparam int          N_VECTORS           = 16;
  localparam logic [15:0] TT_EXPECTED_XOR_AND = 16'h7888;

  // One when a sampled bit disagrees with its golden bit, sized for the mismatch counter.
  function automatic logic [4:0] bit_mismatch(input logic sampled, input logic golden);
    return {4'd0, sampled ^ golden};
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Per-vector hold timer: restarts on load_i, last_o flags the final hold cycle while enabled.
// Latency: last_o is combinational from the count; no backpressure.
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic last_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = en_i && (cnt_q == 4'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps {a,b,c,d} over 0..15, holds each for SETTLE_CYCLES, captures q into table_out; optional TT_CHECK_EN adds mismatch_cnt/pass.
// Sweep takes 16*SETTLE_CYCLES busy cycles plus one DONE cycle; start is only honoured in IDLE, never queued.
module truth_table_capture
  import tt_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = TT_EXPECTED_XOR_AND
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        q,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out
`ifdef TT_CHECK_EN
  ,
  output logic [4:0]  mismatch_cnt,
  output logic        pass
`endif
);

  tt_state_e   state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] table_q, table_d;
  logic        sweep_start;
  logic        vec_last;
  logic        last_vec;

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load_i(sweep_start || vec_last),
    .en_i  (state_q == APPLY),
    .last_o(vec_last)
  );

  assign last_vec = (idx_q == 4'(N_VECTORS - 1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    table_d     = table_q;
    sweep_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = APPLY;
          idx_d       = '0;
          table_d     = '0;
          sweep_start = 1'b1;
        end
      end
      APPLY: begin
        if (vec_last) begin
          table_d[idx_q] = q;
          if (last_vec) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
    end
  end

  assign busy         = (state_q == APPLY);
  assign done         = (state_q == DONE);
  assign {a, b, c, d} = busy ? idx_q : 4'd0;
  assign table_out    = table_q;

`ifdef TT_CHECK_EN
  logic [4:0] mism_q, mism_d;
  logic       pass_q, pass_d;

  // pass is resolved on the edge into DONE so it is already valid during the done pulse.
  always_comb begin
    mism_d = mism_q;
    pass_d = pass_q;
    if (sweep_start) begin
      mism_d = '0;
      pass_d = 1'b0;
    end else if (busy && vec_last) begin
      mism_d = mism_q + bit_mismatch(q, EXPECTED[idx_q]);
      if (last_vec) begin
        pass_d = (mism_d == 5'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mism_q <= '0;
      pass_q <= 1'b0;
    end else begin
      mism_q <= mism_d;
      pass_q <= pass_d;
    end
  end

  assign mismatch_cnt = mism_q;
  assign pass         = pass_q;
`endif

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: random gate functions on a 2-cycle-settle instance, plus a
// 1-cycle-settle instance whose q comes through one register (checks honour TT_CHECK_EN).
module tb_truth_table_capture;
  import tt_pkg::*;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst, start, start1;
  logic        a, b, c, d, busy, done;
  logic        a1, b1, c1, d1, busy1, done1;
  logic        q, q1_q;
  logic [15:0] table_out, table_out1;
  logic [15:0] fn, fn1;
`ifdef TT_CHECK_EN
  logic [4:0]  mismatch_cnt, mismatch_cnt1;
  logic        pass, pass1;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Gate under test is a plain lookup of the current function table.
  assign q = fn[{a, b, c, d}];
  always @(posedge clk) q1_q <= fn1[{a1, b1, c1, d1}];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  truth_table_capture #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c), .d(d), .q(q),
    .busy(busy), .done(done), .table_out(table_out)
`ifdef TT_CHECK_EN
    , .mismatch_cnt(mismatch_cnt), .pass(pass)
`endif
  );

  truth_table_capture #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1), .q(q1_q),
    .busy(busy1), .done(done1), .table_out(table_out1)
`ifdef TT_CHECK_EN
    , .mismatch_cnt(mismatch_cnt1), .pass(pass1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full sweep on dut; optionally re-pulses start at APPLY cycle poke_at.
  task automatic sweep(input logic [15:0] f, input int poke_at);
    fn = f;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 16 * S; k++) begin
      chk("busy", 32'(busy), 32'd1);
      chk("vec", 32'({a, b, c, d}), 32'(k / S));
      chk("no_done", 32'(done), 32'd0);
      if (k == 0) chk("tbl_clr", 32'(table_out), 32'd0);
`ifdef TT_CHECK_EN
      chk("pass_busy", 32'(pass), 32'd0);
`endif
      start = (k == poke_at);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("vec_done", 32'({a, b, c, d}), 32'd0);
    chk("table", 32'(table_out), 32'(f));
`ifdef TT_CHECK_EN
    chk("mism", 32'(mismatch_cnt), 32'($countones(f ^ 16'h7888)));
    chk("pass", 32'(pass), 32'(f == 16'h7888));
`endif
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_table", 32'(table_out), 32'(f));
  endtask

  initial begin
    int t0;
    int t1;
    int n;
    bit seen;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; fn = 16'h0; fn1 = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vec", 32'({a, b, c, d}), 32'd0);
    chk("rst_table", 32'(table_out), 32'd0);
`ifdef TT_CHECK_EN
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_mism", 32'(mismatch_cnt), 32'd0);
`endif
    // start together with rst must be ignored
    start = 1'b1;
    @(negedge clk);
    chk("rst_prio", 32'(busy), 32'd0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);

    sweep(16'h7888, -1);
    sweep(16'h0000, -1);
    sweep(16'h7888, 10);
    repeat (4) sweep(16'($urandom), -1);

    // Mid-sweep reset discards partial results and never pulses done.
    fn = 16'hFFFF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_rst_tbl", 32'(table_out != 16'h0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_table", 32'(table_out), 32'd0);
    chk("abort_vec", 32'({a, b, c, d}), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_nodone", 32'(seen), 32'd0);

    // Continuous start: back-to-back sweeps with a single IDLE gap.
    fn = 16'h7888;
    t0 = 0;
    t1 = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 16 * S; k++) begin
        chk("cont_busy", 32'(busy), 32'd1);
        chk("cont_vec", 32'({a, b, c, d}), 32'(k / S));
        @(negedge clk);
      end
      chk("cont_done", 32'(done), 32'd1);
      if (s == 0) t0 = cyc; else t1 = cyc;
      if (s == 1) start = 1'b0;
      @(negedge clk);
      chk("cont_gap", 32'(busy | done), 32'd0);
      @(negedge clk);
    end
    chk("cont_period", 32'(t1 - t0), 32'd34);
    chk("cont_stop", 32'(busy), 32'd0);

    // SETTLE_CYCLES=1 with registered q: each bit captures the previous vector's result.
    for (int r = 0; r < 2; r++) begin
      fn1 = (r == 0) ? 16'h7888 : 16'($urandom);
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      n = 0;
      while (!done1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("s1_latency", 32'(n), 32'd16);
      chk("s1_table", 32'(table_out1), 32'({fn1[14:0], fn1[0]}));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_capture.md
TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the number of cycles each input vector is held before q is sampled (legal 1..15).
REQ-002 The block SHALL have parameter EXPECTED, default 16'h7888, the golden truth table of (a & b) ^ (c & d), where bit i corresponds to {a,b,c,d} = i.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: requests a sweep; it is sampled only in IDLE.
REQ-006 The block SHALL have ports a, b, c and d, each an output of 1 bit, driving the gate under test.
REQ-007 The block SHALL have port q, input, 1 bit: the gate-under-test result.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a sweep.
REQ-010 The block SHALL have port table_out, output, 16 bits: the captured truth table.

Function
REQ-011 The FSM SHALL have states IDLE, APPLY, DONE.
REQ-012 In IDLE, start=1 SHALL move the FSM to APPLY at the next edge, clear table_out, set the vector index to 0 and clear the hold counter.
REQ-013 In APPLY, {a,b,c,d} SHALL equal the 4-bit vector index, and each vector SHALL be held for exactly SETTLE_CYCLES cycles.
REQ-014 On the edge that ends the last hold cycle of vector i, q SHALL be written to table_out[i].
REQ-015 After vector 15 is sampled, the FSM SHALL enter DONE; the index SHALL NOT wrap back to 0 within a sweep.
REQ-016 DONE SHALL last one cycle with done=1, busy=0 and {a,b,c,d}=0, then the FSM SHALL return to IDLE.
REQ-017 busy SHALL be 1 exactly while in APPLY, which lasts 16*SETTLE_CYCLES cycles.
REQ-018 start SHALL be ignored in APPLY and DONE, with no restart and no queuing.
REQ-019 start held high continuously SHALL begin a new sweep in the cycle after DONE, i.e. one IDLE cycle between sweeps.
REQ-020 In IDLE, {a,b,c,d} SHALL be 0 and table_out SHALL hold the last completed table.

Reset
REQ-021 With rst=1 at an edge, the FSM SHALL go to IDLE, with a=b=c=d=0, busy=0, done=0, table_out=0, index=0 and counter=0.
REQ-022 rst SHALL take priority over start.
REQ-023 A mid-sweep rst SHALL abort the sweep without a done pulse and discard partial results.

Configuration
REQ-024 When macro TT_CHECK_EN is defined, the block SHALL add outputs mismatch_cnt (5 bits) and pass (1 bit).
REQ-025 With TT_CHECK_EN defined, mismatch_cnt SHALL count the sampled bits that differ from EXPECTED (0..16), SHALL be cleared at sweep start and on reset, and pass SHALL be 1 in DONE and afterwards iff mismatch_cnt==0.
REQ-026 With TT_CHECK_EN defined, pass SHALL be 0 on reset and while busy.
REQ-027 When TT_CHECK_EN is undefined, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 Shared package tt_pkg SHALL hold the state enum, the constant N_VECTORS=16 and the constant TT_EXPECTED_XOR_AND=16'h7888.
REQ-029 The hold counter SHALL be a sub-module, tt_settle_timer: it loads on a vector start and pulses on the last hold cycle.

Verification
REQ-030 Connect the AND-XOR gate with SETTLE_CYCLES=2 and pulse start -> busy high for 32 cycles, one done pulse, table_out=16'h7888 (pass=1, mismatch_cnt=0 if TT_CHECK_EN).
REQ-031 Tie q=0 -> table_out=16'h0000 (mismatch_cnt=6, pass=0 if TT_CHECK_EN).
REQ-032 Pulse start again during a sweep at cycle 10 -> no effect; done occurs at the same cycle as without the extra pulse.
REQ-033 Assert rst at cycle 15 of a sweep -> next cycle busy=0, table_out=0, a..d=0, and no done pulse thereafter.
REQ-034 Hold start=1 continuously -> done pulses 34 cycles apart and a..d count 0..15 with each value held 2 cycles.
REQ-035 Set SETTLE_CYCLES=1 with q delayed by one register -> table_out is shifted by one index (16'hF110), showing that the sample point is the last hold cycle.
